lcd_de_receiver: RTL and testbench
==================================

# lcd_de_receiver

Sink-side counterpart of the DE-mode RGB565 LCD output path. It takes a parallel pixel stream (`DE` plus 5/6/5 RGB) on the pixel clock and finds frame and line boundaries from `DE` run lengths alone. It writes each active pixel into a BSRAM framebuffer through a simple write port, and reports the measured active geometry and timing errors. It is used for loopback self-test of the LCD timing generator and for capturing an external DE-only video source.

## Interface
- `H_ACTIVE`, 480: expected active pixels per line.
- `V_ACTIVE`, 272: expected active lines per frame.
- `VGAP_MIN`, 1024: minimum DE-low run, in clocks, classified as vertical blank. Must exceed the horizontal blank (51 clocks).
- `ADDR_W`, 17: framebuffer address width. Requires `H_ACTIVE*V_ACTIVE <= 2**ADDR_W`.
- `PixelClk` in 1: pixel clock, the only clock.
- `RST` in 1: asynchronous, active-high reset.
- `DE` in 1: data enable, high during active pixels.
- `R` in 5, `G` in 6, `B` in 5: pixel colour.
- `wr_en` out 1: framebuffer write strobe.
- `wr_addr` out `ADDR_W`: framebuffer address, y*H_ACTIVE+x.
- `wr_data` out 16: pixel, packed {R,G,B}.
- `frame_start` out 1: one-cycle pulse coincident with the write of pixel (0,0).
- `locked` out 1: high once a vertical blank has been seen. Pixels are written only while locked.
- `meas_width` out 11: DE-high run length of the most recent line.
- `meas_height` out 10: line count of the most recent complete frame.
- `err_width` out 1: one-cycle pulse, last line length was not equal to H_ACTIVE.
- `err_height` out 1: one-cycle pulse, last frame line count was not equal to V_ACTIVE.

## Operation
- Input stage: `DE`, R, G and B are registered once (`de_q`, `pix_q`). All logic below operates on `de_q`.
- State machine states are SEEK, LINE, HBLANK and VBLANK. Reset enters SEEK.
  - SEEK: count DE-low clocks. When the gap counter reaches VGAP_MIN, go to VBLANK. DE-high clears the gap counter.
  - VBLANK: on `de_q` rising, set `locked`=1, set x=0 and y=0, arm `frame_start`, and go to LINE.
  - LINE: every clock with `de_q`=1, if x<H_ACTIVE and y<V_ACTIVE, write the pixel, then x++. x saturates at 2047. On `de_q` falling:
    - latch `meas_width`=x;
    - pulse `err_width` if x≠H_ACTIVE;
    - y++ (saturates at 1023);
    - go to HBLANK.
  - HBLANK: gap counter counts. A `de_q` rise goes to LINE with x=0. If the gap counter reaches VGAP_MIN, go to VBLANK and end the frame:
    - latch `meas_height`=y;
    - pulse `err_height` if y≠V_ACTIVE.
- The gap counter saturates at VGAP_MIN. It is cleared on every `de_q` rise.
- Address generation uses no multiplier:
  - a `line_base` register is cleared at frame start and adds H_ACTIVE at each line end;
  - `wr_addr`=line_base+x, computed in ADDR_W bits.
- Short line: the missing pixels are not written, and the next line still starts at y*H_ACTIVE.
- Long line: pixels beyond H_ACTIVE-1 are dropped.
- Tall frame: lines at or beyond V_ACTIVE are dropped.
- DE-high at the first clock after reset: treated as mid-frame. Stay in SEEK.
- `locked` is never cleared except by reset.
- Reset mid-frame: all state is cleared immediately. Capture resumes only after the next VGAP_MIN gap.

## Timing
- Reset values: `wr_en` 0, `wr_addr` 0, `wr_data` 0, `frame_start` 0, `locked` 0, `meas_width` 0, `meas_height` 0, `err_width` 0, `err_height` 0.
- All outputs are registered.
- Latency: a pixel presented at edge k (DE=1) gives `wr_en`/`wr_addr`/`wr_data` valid after edge k+2.
- `err_width` asserts 2 clocks after the DE-low input sample that ends the line.
- `err_height` asserts 2 clocks after the clock on which the gap counter reaches VGAP_MIN.
- `wr_en` is a single-cycle strobe per pixel. There is no backpressure: the BSRAM must accept one write per clock.
- Simultaneous line end and VBLANK entry cannot occur, because VGAP_MIN is greater than 1.

## Structure
- Package `lcd_rx_pkg` holds:
  - `rx_state_t` enum (SEEK, LINE, HBLANK, VBLANK);
  - the RGB565 packing function;
  - default geometry constants (480, 272, 1024).
- No sub-module. The gap counter and address generator are small enough to stay inline.

## Test plan
- Loopback 480x272 frames at 531x292 timing -> after the first full vertical blank, `locked`=1.
  - `frame_start` pulses once per frame.
  - 130560 writes per frame; last `wr_addr`=130559.
  - `meas_width`=480, `meas_height`=272, no error pulses.
- Pixel (x=5, y=3) with R=0x1F, G=0, B=0 -> a write at `wr_addr`=1445 with `wr_data`=0xF800, exactly 2 clocks after input.
- One line of 470 DE clocks in mid-frame -> `err_width` pulse and `meas_width`=470.
  - The next line's first `wr_addr` is still (y+1)*480.
- Frame of 275 lines, each 490 wide ->
  - `err_height` with `meas_height`=275;
  - `err_width` on every line;
  - no write with `wr_addr`≥130560.
- Start stimulus mid-frame at line 100 -> zero writes and `locked`=0 until the vertical blank. The next frame then captures normally.
- Assert `RST` for 1 clock at pixel 200 of line 50 -> all outputs return to their reset values and `locked`=0. The remainder of the frame is not written, and capture resumes on the following frame.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// rtl/lcd_rx_pkg.sv - shared types, constants and helpers for the DE-mode LCD receiver
//
// Contents:
//   rx_state_t      - receiver state machine encoding
//   DEF_H_ACTIVE    - default active pixels per line
//   DEF_V_ACTIVE    - default active lines per frame
//   DEF_VGAP_MIN    - default DE-low run length taken as vertical blank
//   pack_rgb565()   - packs 5/6/5 colour components into one 16-bit pixel
package lcd_rx_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } rx_state_t;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_VGAP_MIN = 1024;

  function automatic logic [15:0] pack_rgb565(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/lcd_de_receiver.sv
// rtl/lcd_de_receiver.sv - DE-only RGB565 sink: frame/line recovery, framebuffer writes, geometry check
//
// Ports:
//   PixelClk     in   pixel clock (only clock)
//   RST          in   asynchronous active-high reset
//   DE, R, G, B  in   data enable and 5/6/5 pixel colour
//   wr_en        out  framebuffer write strobe, one per captured pixel
//   wr_addr      out  framebuffer address, y*H_ACTIVE+x
//   wr_data      out  packed {R,G,B}
//   frame_start  out  one-cycle pulse alongside the write of pixel (0,0)
//   locked       out  set at the first frame start after a vertical blank, held until reset
//   meas_width   out  DE-high run length of the most recent line
//   meas_height  out  line count of the most recent complete frame
//   err_width    out  one-cycle pulse, last line length differed from H_ACTIVE
//   err_height   out  one-cycle pulse, last frame line count differed from V_ACTIVE
import lcd_rx_pkg::*;

module lcd_de_receiver #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VGAP_MIN = DEF_VGAP_MIN,
  parameter int ADDR_W   = 17
) (
  input  logic              PixelClk,
  input  logic              RST,
  input  logic              DE,
  input  logic [4:0]        R,
  input  logic [5:0]        G,
  input  logic [4:0]        B,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_start,
  output logic              locked,
  output logic [10:0]       meas_width,
  output logic [9:0]        meas_height,
  output logic              err_width,
  output logic              err_height
);

  localparam int          GAP_W = $clog2(VGAP_MIN + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(VGAP_MIN);
  localparam logic [GAP_W-1:0] GAP_PRE = GAP_W'(VGAP_MIN - 1);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  logic              de_q;
  logic [15:0]       pix_q;
  rx_state_t         state;
  logic [10:0]       x;
  logic [9:0]        y;
  logic [ADDR_W-1:0] line_base;
  logic [GAP_W-1:0]  gap;

  logic              gap_hit;
  logic [10:0]       x_cur;
  logic [9:0]        y_cur;
  logic [ADDR_W-1:0] base_cur;
  logic              pix_ok;

  // The DE-low clock that takes the gap counter to VGAP_MIN; fires once per gap.
  assign gap_hit = !de_q && (gap == GAP_PRE);

  // A rising de_q seen in HBLANK/VBLANK is itself pixel 0 of the new line, so
  // the write coordinates are taken as they will be after that transition.
  always_comb begin
    x_cur    = (state == LINE)   ? x  : 11'd0;
    y_cur    = (state == VBLANK) ? 10'd0 : y;
    base_cur = (state == VBLANK) ? '0 : line_base;
    pix_ok   = de_q && (state != SEEK) && (x_cur < H_LIM) && (y_cur < V_LIM);
  end

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      de_q        <= 1'b0;
      pix_q       <= '0;
      state       <= SEEK;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      gap         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
    end else begin
      de_q        <= DE;
      pix_q       <= pack_rgb565(R, G, B);
      wr_en       <= pix_ok;
      frame_start <= 1'b0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;

      if (pix_ok) begin
        wr_addr <= base_cur + ADDR_W'(x_cur);
        wr_data <= pix_q;
      end

      if (de_q)
        gap <= '0;
      else if (gap != GAP_MAX)
        gap <= gap + 1'b1;

      case (state)
        SEEK: begin
          if (gap_hit) state <= VBLANK;
        end
        VBLANK: begin
          if (de_q) begin
            locked      <= 1'b1;
            frame_start <= 1'b1;
            x           <= 11'd1;
            y           <= '0;
            line_base   <= '0;
            state       <= LINE;
          end
        end
        LINE: begin
          if (de_q) begin
            if (x != 11'h7FF) x <= x + 1'b1;
          end else begin
            meas_width <= x;
            err_width  <= (x != H_LIM);
            if (y != 10'h3FF) y <= y + 1'b1;
            line_base  <= line_base + H_STEP;
            state      <= HBLANK;
          end
        end
        HBLANK: begin
          if (de_q) begin
            x     <= 11'd1;
            state <= LINE;
          end else if (gap_hit) begin
            meas_height <= y;
            err_height  <= (y != V_LIM);
            state       <= VBLANK;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_de_receiver.sv
// tb/tb_lcd_de_receiver.sv - directed self-checking bench for lcd_de_receiver
module tb_lcd_de_receiver;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int VG = 64;
  localparam int AW = 17;
  localparam int HG = 11;
  localparam int VTAIL = 59;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          de  = 1'b0;
  logic [4:0]    r   = '0;
  logic [5:0]    g   = '0;
  logic [4:0]    b   = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_start;
  logic          locked;
  logic [10:0]   meas_width;
  logic [9:0]    meas_height;
  logic          err_width;
  logic          err_height;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nwr = 0, nfs = 0, new_cnt = 0, neh = 0, bad_addr = 0;
  int c53 = -100, w53 = -1;
  int bad_data;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] wr_log [0:255];
  logic [15:0]   mem [0:127];

  lcd_de_receiver #(.H_ACTIVE(H), .V_ACTIVE(V), .VGAP_MIN(VG), .ADDR_W(AW)) dut (
    .PixelClk(clk), .RST(rst), .DE(de), .R(r), .G(g), .B(b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .locked(locked),
    .meas_width(meas_width), .meas_height(meas_height),
    .err_width(err_width), .err_height(err_height)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      if (nwr < 256) wr_log[nwr] = wr_addr;
      nwr++;
      last_addr = wr_addr;
      if (wr_addr >= AW'(H * V)) bad_addr++;
      else mem[wr_addr[6:0]] = wr_data;
      if (wr_addr == AW'(53)) w53 = cyc;
    end
    if (frame_start) nfs++;
    if (err_width)   new_cnt++;
    if (err_height)  neh++;
  end

  function automatic logic [15:0] exp_pix(input int x, input int y);
    if (x == 5 && y == 3) return 16'hF800;
    return {5'(x), 6'(y), 5'(x + y)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y);
    logic [15:0] p;
    p  = exp_pix(x, y);
    de = 1'b1;
    r  = p[15:11];
    g  = p[10:5];
    b  = p[4:0];
    if (x == 5 && y == 3) c53 = cyc;
  endtask

  task automatic line(input int w, input int y);
    for (int i = 0; i < w; i++) begin
      drive_pix(i, y);
      tick();
    end
    de = 1'b0;
    repeat (HG) tick();
  endtask

  task automatic frame(input int w, input int nlines);
    for (int y = 0; y < nlines; y++) line(w, y);
    de = 1'b0;
    repeat (VTAIL) tick();
  endtask

  task automatic clear_counts();
    nwr = 0; nfs = 0; new_cnt = 0; neh = 0; bad_addr = 0;
    for (int a = 0; a < 128; a++) mem[a] = 16'hDEAD;
  endtask

  task automatic count_bad_data(input int skip_lo, input int skip_hi);
    bad_data = 0;
    for (int a = 0; a < H * V; a++)
      if ((a < skip_lo || a > skip_hi) && mem[a] !== exp_pix(a % H, a / H)) bad_data++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},       32'(wr_en),       32'd0);
    check({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
    check({tag, "_wr_data"},     32'(wr_data),     32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_locked"},      32'(locked),      32'd0);
    check({tag, "_meas_width"},  32'(meas_width),  32'd0);
    check({tag, "_meas_height"}, 32'(meas_height), 32'd0);
    check({tag, "_err_width"},   32'(err_width),   32'd0);
    check({tag, "_err_height"},  32'(err_height),  32'd0);
  endtask

  initial begin
    // Reset with DE already high: the stream starts in the middle of line 5.
    drive_pix(0, 5);
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    clear_counts();
    for (int i = 1; i < H; i++) begin drive_pix(i, 5); tick(); end
    de = 1'b0;
    repeat (HG) tick();
    line(H, 6);
    line(H, 7);
    check("midframe_writes", 32'(nwr), 32'd0);
    check("midframe_locked", 32'(locked), 32'd0);
    repeat (VTAIL) tick();
    check("vblank_locked_before_rise", 32'(locked), 32'd0);

    // First full frame after the vertical blank.
    clear_counts();
    frame(H, V);
    check("f1_locked",      32'(locked),      32'd1);
    check("f1_writes",      32'(nwr),         32'd128);
    check("f1_frame_start", 32'(nfs),         32'd1);
    check("f1_last_addr",   32'(last_addr),   32'd127);
    check("f1_meas_width",  32'(meas_width),  32'd16);
    check("f1_meas_height", 32'(meas_height), 32'd8);
    check("f1_err_width",   32'(new_cnt),     32'd0);
    check("f1_err_height",  32'(neh),         32'd0);
    check("pix53_data",     32'(mem[53]),     32'hF800);
    check("pix53_latency",  32'(w53 - c53),   32'd2);
    count_bad_data(-1, -1);
    check("f1_data", 32'(bad_data), 32'd0);

    // Short line (14 pixels) at y=2.
    clear_counts();
    line(H, 0);
    line(H, 1);
    line(14, 2);
    check("short_err_width",  32'(new_cnt),    32'd1);
    check("short_meas_width", 32'(meas_width), 32'd14);
    line(H, 3);
    for (int y = 4; y < V; y++) line(H, y);
    de = 1'b0;
    repeat (VTAIL) tick();
    check("short_next_line_addr", 32'(wr_log[46]), 32'd48);
    check("short_writes",         32'(nwr),        32'd126);
    check("short_unwritten_46",   32'(mem[46]),    32'hDEAD);
    check("short_unwritten_47",   32'(mem[47]),    32'hDEAD);
    check("short_err_height",     32'(neh),        32'd0);
    check("short_meas_height",    32'(meas_height), 32'd8);
    count_bad_data(46, 47);
    check("short_data", 32'(bad_data), 32'd0);

    // Tall and wide frame: 10 lines of 20 pixels.
    clear_counts();
    frame(20, 10);
    check("tall_err_height",  32'(neh),         32'd1);
    check("tall_meas_height", 32'(meas_height), 32'd10);
    check("tall_err_width",   32'(new_cnt),     32'd10);
    check("tall_meas_width",  32'(meas_width),  32'd20);
    check("tall_bad_addr",    32'(bad_addr),    32'd0);
    check("tall_writes",      32'(nwr),         32'd128);

    // One-clock reset at pixel 10 of line 4.
    clear_counts();
    for (int y = 0; y < 4; y++) line(H, y);
    for (int i = 0; i < 10; i++) begin drive_pix(i, 4); tick(); end
    drive_pix(10, 4);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    nwr = 0;
    tick();
    rst = 1'b0;
    for (int i = 11; i < H; i++) begin drive_pix(i, 4); tick(); end
    de = 1'b0;
    repeat (HG) tick();
    for (int y = 5; y < V; y++) line(H, y);
    check("midrst_no_writes", 32'(nwr), 32'd0);
    check("midrst_locked",    32'(locked), 32'd0);
    repeat (VTAIL) tick();

    clear_counts();
    frame(H, V);
    check("resume_locked",      32'(locked),      32'd1);
    check("resume_writes",      32'(nwr),         32'd128);
    check("resume_frame_start", 32'(nfs),         32'd1);
    check("resume_meas_height", 32'(meas_height), 32'd8);
    check("resume_last_addr",   32'(last_addr),   32'd127);
    count_bad_data(-1, -1);
    check("resume_data", 32'(bad_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
